// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding imem requests and
// buffers returned {pc,instr} pairs in a small prefetch queue presented to the datapath.
module instr_fetch_queue #(
  parameter int             n        = 16,
  parameter int             DEPTH    = 4,
  parameter logic [n-1:0]   RESET_PC = {n{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [n-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [n-1:0] instr,
  output logic [n-1:0] pc,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [n-1:0]   PC_STEP  = n'(2'd2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [n-1:0]    fetch_pc_r, fetch_pc_next_s;
  logic [n-1:0]    imem_addr_r;
  logic            imem_req_r;
  logic            valid_r;
  logic [AW-1:0]   head_r, tail_r;
  logic [AW:0]     count_r, count_after_s;
  logic [n-1:0]    mem_pc_r    [DEPTH];
  logic [n-1:0]    mem_instr_r [DEPTH];
  logic            pop_s, push_s;

  // A redirect flushes the queue, so it suppresses any same-cycle pop or push.
  assign pop_s         = (count_r != {(AW+1){1'b0}}) && instr_ready && !redirect;
  assign push_s        = (state_r == WAIT) && imem_rvalid && !redirect;
  assign count_after_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};

  // Next fetch state and fetch PC.
  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next_s = redirect_pc;
        end else if (count_r < FULL_CNT) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_next_s = redirect_pc;
          state_next_s    = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          fetch_pc_next_s = fetch_pc_r + PC_STEP;
          state_next_s    = (count_after_s < FULL_CNT) ? WAIT : IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_next_s = redirect_pc;
        end else begin
          fetch_pc_next_s = fetch_pc_r;
        end
        state_next_s = imem_rvalid ? IDLE : DROP;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state, fetch PC, request outputs and queue pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      fetch_pc_r  <= RESET_PC;
      imem_addr_r <= RESET_PC;
      imem_req_r  <= 1'b0;
      valid_r     <= 1'b0;
      head_r      <= {AW{1'b0}};
      tail_r      <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      // The abandoned request stays on the bus with its stale address until answered.
      imem_addr_r <= (state_next_s == DROP) ? imem_addr_r : fetch_pc_next_s;
      imem_req_r  <= (state_next_s != IDLE);
      if (redirect) begin
        head_r  <= {AW{1'b0}};
        tail_r  <= {AW{1'b0}};
        count_r <= {(AW+1){1'b0}};
        valid_r <= 1'b0;
      end else begin
        head_r  <= head_r + {{(AW-1){1'b0}}, pop_s};
        tail_r  <= tail_r + {{(AW-1){1'b0}}, push_s};
        count_r <= count_after_s;
        valid_r <= (count_after_s != {(AW+1){1'b0}});
      end
    end
  end

  // Prefetch storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]    <= {n{1'b0}};
        mem_instr_r[i] <= {n{1'b0}};
      end
    end else if (push_s) begin
      mem_pc_r[tail_r]    <= fetch_pc_r;
      mem_instr_r[tail_r] <= imem_rdata;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr_valid = valid_r;
  assign instr       = mem_instr_r[head_r];
  assign pc          = mem_pc_r[head_r];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed table, corner sequences and a
// randomized run against a transaction-level queue model.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  instr_fetch_queue #(.n(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct packed { logic [15:0] pc; logic [15:0] ins; } ent_t;
  ent_t        q[$];
  bit          m_req, m_stale;
  logic [15:0] m_addr, m_fpc;

  int lat  = 1;
  int mcnt = 0;
  bit req_at_drive;

  typedef struct {
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_ins;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_req = 1'b0; m_stale = 1'b0; m_fpc = 16'h0000; m_addr = 16'h0000;
  endtask

  // Transaction-level reference: outstanding-request flag, stale flag and a FIFO.
  task automatic model_step();
    int  pre;
    bit  pop;
    pre = q.size();
    pop = (pre > 0) && instr_ready && !redirect;
    if (redirect) begin
      q.delete();
      m_fpc = redirect_pc;
      if (m_req) begin
        if (imem_rvalid) begin m_req = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_req) begin
        if (pre < DEPTH) begin m_req = 1'b1; m_addr = m_fpc; end
      end else if (imem_rvalid) begin
        if (m_stale) begin
          m_req = 1'b0; m_stale = 1'b0;
        end else begin
          q.push_back('{pc: m_addr, ins: imem_rdata});
          m_fpc = m_fpc + 16'd2;
          if (q.size() < DEPTH) m_addr = m_fpc;
          else m_req = 1'b0;
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " req"}, 32'(imem_req), 32'(m_req));
    chk({tag, " addr"}, 32'(imem_addr), 32'(m_req ? m_addr : m_fpc));
    chk({tag, " valid"}, 32'(instr_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, " pc"}, 32'(pc), 32'(q[0].pc));
      chk({tag, " instr"}, 32'(instr), 32'(q[0].ins));
    end
  endtask

  // Memory: answers addr^A5A5 after 'lat' cycles of a held request.
  task automatic mem_drive();
    req_at_drive = imem_req;
    if (!imem_req) lat = lat;
    if (imem_req && (mcnt + 1 >= lat)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = imem_addr ^ 16'hA5A5;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
  endtask

  task automatic cyc(input string tag);
    mem_drive();
    @(posedge clk);
    model_step();
    if (imem_rvalid || !req_at_drive) mcnt = 0;
    else mcnt++;
    #1;
    model_check(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst async req", 32'(imem_req), 32'd0);
    chk("rst async valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    mcnt = 0;
  endtask

  initial begin
    ent_t        got[$];
    bit          seen;
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    tbl[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA5A5};
    tbl[2] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hA5A7};
    tbl[3] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hA5A1};
    tbl[4] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'hA5A3};

    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset valid", 32'(instr_valid), 32'd0);
    chk("reset instr", 32'(instr), 32'd0);
    chk("reset pc", 32'(pc), 32'd0);
    chk("reset addr", 32'(imem_addr), 32'd0);
    reset = 1'b1;
    model_reset();

    // 1: single-cycle memory streaming, table-driven
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      instr_ready = tbl[i].rdy;
      cyc("t1");
      chk($sformatf("t1[%0d] req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("t1[%0d] addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("t1[%0d] valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("t1[%0d] pc", i), 32'(pc), 32'(tbl[i].e_pc));
        chk($sformatf("t1[%0d] instr", i), 32'(instr), 32'(tbl[i].e_ins));
      end
    end

    // 2: backpressure fills the queue, then drain in order and resume at 8
    do_reset();
    lat = 1; instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc("t2 fill");
    chk("t2 req low when full", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2 pop%0d pc", k), 32'(pc), 32'(2 * k));
      cyc("t2 drain");
      if (imem_req && !seen) begin
        seen = 1'b1;
        chk("t2 resume addr", 32'(imem_addr), 32'h0008);
      end
    end
    chk("t2 resume seen", 32'(seen), 32'd1);

    // 3: redirect while a slow request is outstanding
    do_reset();
    lat = 3; instr_ready = 1'b1;
    cyc("t3");
    redirect = 1'b1; redirect_pc = 16'h0100;
    cyc("t3 redir");
    redirect = 1'b0;
    chk("t3 stale addr", 32'(imem_addr), 32'h0000);
    chk("t3 stale req", 32'(imem_req), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc("t3 wait");
      if (instr_valid) begin
        seen = 1'b1;
        chk("t3 first pc", 32'(pc), 32'h0100);
      end
    end
    chk("t3 got instr", 32'(seen), 32'd1);

    // 4: redirect coincident with rvalid and 2 entries queued
    do_reset();
    lat = 1; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t4 fill");
    chk("t4 queued", 32'(q.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 16'h0040;
    cyc("t4 redir");
    redirect = 1'b0;
    chk("t4 flushed", 32'(instr_valid), 32'd0);
    chk("t4 req idle", 32'(imem_req), 32'd0);
    cyc("t4 reissue");
    chk("t4 req", 32'(imem_req), 32'd1);
    chk("t4 addr", 32'(imem_addr), 32'h0040);

    // 5: PC wraps modulo 2^16
    do_reset();
    lat = 1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    cyc("t5 redir");
    redirect = 1'b0;
    got.delete();
    for (int i = 0; i < 12 && got.size() < 4; i++) begin
      cyc("t5");
      if (instr_valid) got.push_back('{pc: pc, ins: instr});
    end
    chk("t5 count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("t5 pc0", 32'(got[0].pc), 32'hFFFC);
      chk("t5 pc1", 32'(got[1].pc), 32'hFFFE);
      chk("t5 pc2", 32'(got[2].pc), 32'h0000);
      chk("t5 pc3", 32'(got[3].pc), 32'h0002);
    end

    // 6: reset asserted mid-request with 3 entries queued
    do_reset();
    lat = 1; instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("t6 fill");
    chk("t6 queued", 32'(instr_valid && imem_req && q.size() == 3), 32'd1);
    do_reset();
    cyc("t6 restart");
    chk("t6 restart req", 32'(imem_req), 32'd1);
    chk("t6 restart addr", 32'(imem_addr), 32'h0000);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = {16'($urandom) & 16'hFFFE};
      if (!imem_req) lat = $urandom_range(1, 3);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc("rand");
    end
    redirect = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
